// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers.
// Used by the single-clock and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 8;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: register array with one
// synchronous write port and one async read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, level flags,
// sticky error flags and optional FWFT read mode.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = FIFO_MODE_REG
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_inc,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        r_inc,
  input  logic                        clr_err,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [fifo_ptr_w(DEPTH)-1:0] fill_cnt,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] C_FULL = PW'(DEPTH);
  localparam logic [PW-1:0] C_AF   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] C_AE   = PW'(AE_LEVEL);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    cnt;
  logic [WIDTH-1:0] head;
  logic             wr_ok;
  logic             rd_ok;

  assign full         = (cnt == C_FULL);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= C_AF);
  assign almost_empty = (cnt <= C_AE);
  assign fill_cnt     = cnt;

  // full/empty gate requests; no pass-through
  assign wr_ok = w_inc & ~full;
  assign rd_ok = r_inc & ~empty;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  // pointers advance only on accepted ops
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_ok) rd_ptr <= rd_ptr + ONE;
    end
  end

  // fill count: simultaneous ops cancel
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        wr_ok & ~rd_ok: cnt <= cnt + ONE;
        rd_ok & ~wr_ok: cnt <= cnt - ONE;
        default:        cnt <= cnt;
      endcase
    end
  end

  // sticky errors; a new event beats clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_inc & full)
                 | (overflow & ~clr_err);
      underflow <= (r_inc & empty)
                 | (underflow & ~clr_err);
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data  = head;
      assign rd_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_q;
      logic             rv_q;

      // registered read: one-cycle valid pulse
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
          rv_q <= 1'b0;
        end else begin
          rv_q <= rd_ok;
          if (rd_ok) rd_q <= head;
        end
      end

      assign rd_data  = rd_q;
      assign rd_valid = rv_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered and FWFT
// instances share stimulus, checked vs a queue model.
module tb_sync_fifo_flags;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          w_inc = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          r_inc = 1'b0;
  logic          clr_err = 1'b0;

  logic [W-1:0]  r_data, f_data;
  logic          r_valid, f_valid;
  logic          r_full, f_full;
  logic          r_empty, f_empty;
  logic          r_af, f_af;
  logic          r_ae, f_ae;
  logic [CW-1:0] r_cnt, f_cnt;
  logic          r_ovf, f_ovf;
  logic          r_unf, f_unf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] m_rdata;
  bit           m_rvalid;
  bit           m_ovf;
  bit           m_unf;

  always #5 clk = ~clk;

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF),
    .AE_LEVEL(AE), .FWFT(0)
  ) u_reg (
    .clk(clk), .rst(rst), .w_inc(w_inc),
    .wr_data(wr_data), .r_inc(r_inc),
    .clr_err(clr_err), .rd_data(r_data),
    .rd_valid(r_valid), .full(r_full),
    .empty(r_empty), .almost_full(r_af),
    .almost_empty(r_ae), .fill_cnt(r_cnt),
    .overflow(r_ovf), .underflow(r_unf)
  );

  sync_fifo_flags #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF),
    .AE_LEVEL(AE), .FWFT(1)
  ) u_fw (
    .clk(clk), .rst(rst), .w_inc(w_inc),
    .wr_data(wr_data), .r_inc(r_inc),
    .clr_err(clr_err), .rd_data(f_data),
    .rd_valid(f_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .fill_cnt(f_cnt),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("cnt",   32'(r_cnt), 32'(n));
    chk("full",  32'(r_full), 32'(n == D));
    chk("empty", 32'(r_empty), 32'(n == 0));
    chk("af",    32'(r_af), 32'(n >= AF));
    chk("ae",    32'(r_ae), 32'(n <= AE));
    chk("ovf",   32'(r_ovf), 32'(m_ovf));
    chk("unf",   32'(r_unf), 32'(m_unf));
    chk("rvalid", 32'(r_valid), 32'(m_rvalid));
    chk("rdata", 32'(r_data), 32'(m_rdata));
    chk("f_cnt", 32'(f_cnt), 32'(n));
    chk("f_ovf", 32'(f_ovf), 32'(m_ovf));
    chk("f_unf", 32'(f_unf), 32'(m_unf));
    chk("f_valid", 32'(f_valid), 32'(n != 0));
    if (n != 0)
      chk("f_data", 32'(f_data), 32'(q[0]));
  endtask

  // one clock: drive, update model, sample at +1
  task automatic step(input bit w,
                      input logic [W-1:0] d,
                      input bit r,
                      input bit c,
                      input bit rs);
    bit is_full, is_empty;
    w_inc   = w;
    wr_data = d;
    r_inc   = r;
    clr_err = c;
    rst     = rs;
    is_full  = (q.size() == D);
    is_empty = (q.size() == 0);
    if (rs) begin
      q.delete();
      m_rdata  = '0;
      m_rvalid = 0;
      m_ovf    = 0;
      m_unf    = 0;
    end else begin
      m_rvalid = 0;
      if (r && !is_empty) begin
        m_rdata  = q.pop_front();
        m_rvalid = 1;
      end
      if (w && !is_full) q.push_back(d);
      m_ovf = (w && is_full) || (m_ovf && !c);
      m_unf = (r && is_empty) || (m_unf && !c);
    end
    @(posedge clk);
    #1;
    w_inc   = 0;
    r_inc   = 0;
    clr_err = 0;
    rst     = 0;
    check_all();
  endtask

  initial begin
    logic [W-1:0] v;
    int           fc;

    // reset state
    step(0, 0, 0, 0, 1);

    // fill with squares, then drain
    for (int i = 0; i < D; i++) begin
      v = W'(i * i);
      step(1, v, 0, 0, 0);
    end
    for (int i = 0; i < D; i++)
      step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // overflow: write while full
    for (int i = 0; i < D; i++)
      step(1, W'(8'h10 + i), 0, 0, 0);
    step(1, 8'hAA, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < D - 1; i++)
      step(0, 0, 1, 0, 0);

    // underflow, then clear racing a new underflow
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'h77, 0, 0, 0);
    step(0, 0, 1, 0, 0);

    // steady state at 4 with wrap
    for (int i = 0; i < 4; i++)
      step(1, W'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 20; i++)
      step(1, W'(8'h80 + i), 1, 0, 0);
    for (int i = 0; i < 4; i++)
      step(1, W'(8'hC0 + i), 0, 0, 0);
    step(1, 8'hEE, 1, 0, 0);
    for (int i = 0; i < D - 1; i++)
      step(0, 0, 1, 0, 0);

    // FWFT fall-through and registered pulse
    step(1, 8'h5A, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // reset mid-burst
    for (int i = 0; i < 5; i++)
      step(1, W'(8'h20 + i), 0, 0, 0);
    step(1, 8'h99, 1, 1, 1);
    step(1, 8'h3C, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      fc = int'($urandom_range(0, 99));
      step($urandom_range(0, 99) < 55,
           W'($urandom),
           $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 6,
           fc < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
